// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_lsu load/store data memory:
// funct3 encodings, access size enum, FSM states and legality checks.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e sz);
        case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Size lives in the low two funct3 bits for both loads and stores.
    function automatic size_e f3_size(input logic [2:0] f3);
        return size_e'(f3[1:0]);
    endfunction

    // wide = 1 when the datapath is 64 bits, enabling LD, LWU and SD.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3, input logic wide);
        if (we)
            return (f3[2] == 1'b0) && (wide || (f3 != F3_D));
        else
            return (f3 != 3'b111) && (wide || ((f3 != F3_D) && (f3 != F3_WU)));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage (master) and dmem_lsu (slave).
interface dmem_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte mask and data replication,
// and load lane extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  size_e             st_size,
    input  logic [OFF_W-1:0]  st_off,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [NB-1:0]     st_mask,
    output logic [DATA_W-1:0] st_wdata_rep,
    input  size_e             ld_size,
    input  logic              ld_unsigned,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [DATA_W-1:0] ld_word,
    output logic [DATA_W-1:0] ld_data
);

    logic [3:0]        st_nbytes;
    logic [DATA_W-1:0] ld_shifted;
    logic              ld_fill;
    int                ld_nbits;

    assign st_nbytes = size_bytes(st_size);

    // Aligned accesses let each lane pick its source byte as lane mod size.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        localparam int SRC_H = gi % 2;
        localparam int SRC_W = gi % 4;
        localparam int SRC_D = gi % 8;

        assign st_mask[gi] = (int'(st_off) <= gi) &&
                             (gi < int'(st_off) + int'(st_nbytes));

        assign st_wdata_rep[gi*8 +: 8] =
            (st_size == SZ_B) ? st_wdata[7:0]          :
            (st_size == SZ_H) ? st_wdata[SRC_H*8 +: 8] :
            (st_size == SZ_W) ? st_wdata[SRC_W*8 +: 8] :
                                st_wdata[SRC_D*8 +: 8];
    end

    assign ld_shifted = ld_word >> {ld_off, 3'b000};

    always_comb begin
        ld_nbits = 8 * int'(size_bytes(ld_size));
        case (ld_size)
            SZ_B:    ld_fill = ld_shifted[7];
            SZ_H:    ld_fill = ld_shifted[15];
            SZ_W:    ld_fill = ld_shifted[31];
            default: ld_fill = ld_shifted[DATA_W-1];
        endcase
        if (ld_unsigned)
            ld_fill = 1'b0;
        ld_data = '0;
        for (int i = 0; i < DATA_W; i++)
            ld_data[i] = (i < ld_nbits) ? ld_shifted[i] : ld_fill;
    end

endmodule

// File: rtl/dmem_lsu.sv
// RISC-V load/store data memory with post-reset zero sweep and 1-cycle reads.
// Optional macro DMEM_BOUNDS_CHECK_EN: fault on address bits above the array.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 64
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    state_e            state_reg;
    logic [IDX_W-1:0]  cnt_reg;
    logic              ready_reg;
    logic              rsp_valid_reg;
    logic              rsp_fault_reg;
    logic              ld_ok_reg;
    size_e             ld_size_reg;
    logic              ld_unsigned_reg;
    logic [OFF_W-1:0]  ld_off_reg;
    logic [DATA_W-1:0] rd_word_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    size_e             req_size;
    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [3:0]        req_nbytes;
    logic              misaligned;
    logic              range_fault;
    logic              req_fault;
    logic              do_store;
    logic              do_load;

    logic [NB-1:0]     st_mask;
    logic [DATA_W-1:0] st_wdata_rep;
    logic [DATA_W-1:0] ld_data;

    logic              mem_we;
    logic [NB-1:0]     mem_be;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;

    assign accept     = bus.req_valid && ready_reg;
    assign req_size   = f3_size(bus.req_funct3);
    assign req_off    = bus.req_addr[OFF_W-1:0];
    assign req_idx    = bus.req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_nbytes = size_bytes(req_size);
    assign misaligned = |(req_off & OFF_W'(req_nbytes - 4'd1));

`ifdef DMEM_BOUNDS_CHECK_EN
    if (ADDR_W > OFF_W + IDX_W) begin : g_bounds
        assign range_fault = |bus.req_addr[ADDR_W-1:OFF_W+IDX_W];
    end else begin : g_no_bounds
        assign range_fault = 1'b0;
    end
`else
    // Upper address bits are deliberately ignored: the index wraps.
    if (ADDR_W > OFF_W + IDX_W) begin : g_wrap
        logic unused_upper_addr;
        assign unused_upper_addr = ^bus.req_addr[ADDR_W-1:OFF_W+IDX_W];
    end
    assign range_fault = 1'b0;
`endif

    assign req_fault = !f3_legal(bus.req_we, bus.req_funct3, DATA_W == 64)
                       || misaligned || range_fault;
    assign do_store  = accept && bus.req_we && !req_fault;
    assign do_load   = accept && !bus.req_we && !req_fault;

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .st_size      (req_size),
        .st_off       (req_off),
        .st_wdata     (bus.req_wdata),
        .st_mask      (st_mask),
        .st_wdata_rep (st_wdata_rep),
        .ld_size      (ld_size_reg),
        .ld_unsigned  (ld_unsigned_reg),
        .ld_off       (ld_off_reg),
        .ld_word      (rd_word_reg),
        .ld_data      (ld_data)
    );

    // The sweep owns the write port in INIT; requests cannot be accepted then.
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_idx   = req_idx;
        mem_wdata = st_wdata_rep;
        if (state_reg == ST_INIT) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_idx   = cnt_reg;
            mem_wdata = '0;
        end else if (do_store) begin
            mem_we = 1'b1;
            mem_be = st_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i])
                    mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
        if (do_load)
            rd_word_reg <= mem[req_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_INIT;
            cnt_reg         <= '0;
            ready_reg       <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_fault_reg   <= 1'b0;
            ld_ok_reg       <= 1'b0;
            ld_size_reg     <= SZ_B;
            ld_unsigned_reg <= 1'b0;
            ld_off_reg      <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == IDX_W'(DEPTH - 1)) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                default: ready_reg <= 1'b1;
            endcase

            rsp_valid_reg <= accept;
            rsp_fault_reg <= accept && req_fault;
            ld_ok_reg     <= do_load;
            if (do_load) begin
                ld_size_reg     <= req_size;
                ld_unsigned_reg <= bus.req_funct3[2];
                ld_off_reg      <= req_off;
            end
        end
    end

    assign bus.req_ready = ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_fault = rsp_fault_reg;
    assign bus.rsp_rdata = ld_ok_reg ? ld_data : '0;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data memory with RISC-V load/store semantics: byte, half, word and double accesses, sign/zero extension, misalignment faults and a valid/ready request port. Sits between the CPU MEM stage and its backing array, replacing the fixed 64-bit word-only data memory. Reads are registered with one-cycle latency. After reset the array is swept to zero before the first request is accepted.

## Interface
Parameters:
- DATA_W, 64: data width in bits; 32 or 64 only.
- DEPTH, 256: number of DATA_W words; power of two, at least 2.
- ADDR_W, 64: byte address width.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (load/store size and signedness).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data; the value is taken from the low bytes.
- rsp_valid  output  1  response pulse, one cycle.
- rsp_rdata  output  DATA_W  extended load data; 0 for stores and faults.
- rsp_fault  output  1  access rejected: illegal funct3, misaligned or out of range.

## Operation
- States: INIT, RUN. Reset enters INIT with a zeroed sweep counter.
- INIT: writes 0 to word[cnt] each cycle, cnt = 0 .. DEPTH-1. req_ready = 0. Move to RUN after the write to DEPTH-1; this takes exactly DEPTH cycles.
- RUN: req_ready = 1. A request is accepted when req_valid && req_ready.
- Address decomposition, with OFF_W = log2(DATA_W/8):
  - byte offset = addr[OFF_W-1:0];
  - word index = addr[OFF_W+log2(DEPTH)-1 : OFF_W].
- Loads:
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extended.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended.
- Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- Illegal encodings fault:
  - load 111;
  - store 1xx;
  - when DATA_W = 32: LD, LWU and SD.
- Misaligned access faults: the byte offset is not a multiple of the access size.
- Store path: compute a byte mask from size and offset. Replicate the low bytes of req_wdata across the lanes. Write only the enabled bytes. Other bytes are unchanged.
- Load path: select the lane at the offset and extend it to DATA_W.
- Fault behaviour: no memory write; rsp_rdata = 0; rsp_fault = 1.
- Every accepted request gets exactly one response, stores included.

## Timing
- Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0, req_ready = 0, state = INIT, cnt = 0.
- Request accepted at edge N → rsp_valid = 1 during cycle N+1 only, with rsp_rdata and rsp_fault. Outputs are registered.
- The response port has no backpressure. The consumer must take the response in that cycle.
- Back-to-back requests are accepted every RUN cycle, giving throughput of 1 per cycle.
- Store commits at edge N. A load accepted at edge N+1 returns the new data, so read-after-write has no hazard.
- rsp_valid is low in every cycle following a non-accepting cycle.
- Reset asserted mid-sweep or mid-operation: the in-flight response is dropped and the sweep restarts at cnt = 0. Array contents are not reset asynchronously; only the sweep clears them.
- req_valid during INIT is ignored. The requester holds it until req_ready.

## Configuration
- DMEM_BOUNDS_CHECK_EN defined: an access faults when any address bit above the word index is nonzero (beyond DEPTH*DATA_W/8 bytes). Such accesses do not write.
- DMEM_BOUNDS_CHECK_EN undefined: upper address bits are ignored and the index wraps modulo DEPTH. No range fault exists.

## Structure
- Package dmem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - function size_bytes();
  - the legality check function.
- Sub-module dmem_lane_align (combinational) holds:
  - the store mask and lane replication;
  - load lane extraction and extension.
  It is parametrised by DATA_W.
- The top level holds the FSM, the sweep counter, the array, and the response registers.

## Test plan
- Reset, then hold req_valid = 1 with an LD from 0x0 → req_ready stays 0 for exactly 256 cycles. The first response has rdata 0x0 and fault 0.
- SD 0x1122334455667788 to 0x10, then LB 0x17 → 0x0000000000000011. Then LB 0x10 → 0xFFFFFFFFFFFFFF88. Then LHU 0x16 → 0x0000000000001122.
- SB 0xAB to 0x21 after SD 0 to 0x20, then LD 0x20 → 0x000000000000AB00. The other bytes are unchanged.
- LW 0x22 → fault 1, rdata 0. SH 0x13 → fault 1 and memory unchanged; a following LD 0x10 returns the prior value.
- With DMEM_BOUNDS_CHECK_EN defined, LD 0x800 → fault. Without it, LD 0x800 returns word 0.
- Back-to-back requests SW, LW, LW on consecutive cycles → three consecutive rsp_valid pulses. Then assert rst_n = 0 mid-stream → rsp_valid drops to 0 immediately and INIT restarts.
